// File: rtl/issue_unit.sv
// Adder reservation-station dispatch: register/tag file, operand build, station line issue and jeq stall.
// Define ISSUE_BYPASS_EN to forward same-cycle bus results into the issued line instead of stalling.
module issue_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [15:0] instr,
  output logic        instrReady,
  input  logic [3:0]  nextRA,
  input  logic [1:0]  RAFilled,
  input  logic        floatOutReady,
  input  logic [15:0] floatOut,
  input  logic [3:0]  floatOutSrc,
  input  logic        isJeq,
  input  logic        jeqTaken,
  input  logic        loadOutReady,
  input  logic [15:0] loadOut,
  input  logic [3:0]  loadOutSrc,
  input  logic        ldTagValid,
  input  logic [3:0]  ldTagReg,
  input  logic [3:0]  ldTag,
  output logic        writeEnabled,
  output logic [50:0] line,
  output logic        branchValid,
  output logic        branchTaken
);

  localparam logic [3:0] TAG_NONE = 4'hF;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_JEQ   = 4'd6;

  typedef enum logic {S_RUN, S_BR_WAIT} state_t;

  state_t      r_state;
  logic [15:0] r_val [16];
  logic [3:0]  r_tag [16];

  logic [3:0]  w_op, w_rd, w_ra, w_rb;
  logic [3:0]  w_tag0, w_tag1;
  logic        w_flt_act, w_ld_act;
  logic        w_is_issue_op, w_use_rb, w_writes_rd;
  logic        w_hit0_f, w_hit0_l, w_hit1_f, w_hit1_l;
  logic        w_stall, w_accept;
  logic [15:0] w_val0, w_val1;
  logic        w_rdy0, w_rdy1;
  logic [3:0]  w_src0, w_src1;

  function automatic logic f_hit(input logic [3:0] tag, input logic [3:0] src, input logic act);
    return act && (tag != TAG_NONE) && (tag == src);
  endfunction

  assign w_op = instr[15:12];
  assign w_rd = instr[11:8];
  assign w_ra = instr[7:4];
  assign w_rb = instr[3:0];

  assign w_is_issue_op = (w_op == OP_ADD) || (w_op == OP_ADDI) || (w_op == OP_JEQ);
  assign w_use_rb      = (w_op == OP_ADD) || (w_op == OP_JEQ);
  assign w_writes_rd   = (w_op == OP_ADD) || (w_op == OP_ADDI);

  // floatOut carries the branch register while isJeq is high, so it is not a result then.
  assign w_flt_act = floatOutReady && !isJeq;
  assign w_ld_act  = loadOutReady;

  assign w_tag0 = r_tag[w_ra];
  assign w_tag1 = r_tag[w_rb];

  assign w_hit0_f = f_hit(w_tag0, floatOutSrc, w_flt_act);
  assign w_hit0_l = f_hit(w_tag0, loadOutSrc,  w_ld_act);
  assign w_hit1_f = f_hit(w_tag1, floatOutSrc, w_flt_act);
  assign w_hit1_l = f_hit(w_tag1, loadOutSrc,  w_ld_act);

  // Operand 0 is always ra; the load bus takes precedence over the float bus.
  always_comb begin
    w_val0 = '0;
    w_rdy0 = 1'b0;
    w_src0 = w_tag0;
    if (w_tag0 == TAG_NONE) begin
      w_val0 = r_val[w_ra];
      w_rdy0 = 1'b1;
    end
`ifdef ISSUE_BYPASS_EN
    else if (w_hit0_l) begin
      w_val0 = loadOut;
      w_rdy0 = 1'b1;
      w_src0 = TAG_NONE;
    end else if (w_hit0_f) begin
      w_val0 = floatOut;
      w_rdy0 = 1'b1;
      w_src0 = TAG_NONE;
    end
`endif
  end

  always_comb begin
    w_val1 = '0;
    w_rdy1 = 1'b0;
    w_src1 = w_tag1;
    if (w_op == OP_ADDI) begin
      w_val1 = {12'd0, w_rb};
      w_rdy1 = 1'b1;
      w_src1 = TAG_NONE;
    end else if (w_tag1 == TAG_NONE) begin
      w_val1 = r_val[w_rb];
      w_rdy1 = 1'b1;
    end
`ifdef ISSUE_BYPASS_EN
    else if (w_hit1_l) begin
      w_val1 = loadOut;
      w_rdy1 = 1'b1;
      w_src1 = TAG_NONE;
    end else if (w_hit1_f) begin
      w_val1 = floatOut;
      w_rdy1 = 1'b1;
      w_src1 = TAG_NONE;
    end
`endif
  end

`ifdef ISSUE_BYPASS_EN
  assign w_stall = 1'b0;
`else
  // Without forwarding, hold the instruction one cycle so it reads the snooped value from the file.
  assign w_stall = w_is_issue_op &&
                   (w_hit0_f || w_hit0_l || (w_use_rb && (w_hit1_f || w_hit1_l)));
`endif

  assign instrReady   = !reset && (r_state == S_RUN) && (nextRA != TAG_NONE) &&
                        (RAFilled != 2'd2) && !w_stall;
  assign w_accept     = instrValid && instrReady;
  assign writeEnabled = w_accept && w_is_issue_op;
  assign line         = writeEnabled ? {w_rd, 1'b1, w_op, w_val0, w_rdy0, w_src0,
                                        w_val1, w_rdy1, w_src1} : '0;

  assign branchValid = !reset && (r_state == S_BR_WAIT) && isJeq;
  assign branchTaken = branchValid && jeqTaken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:     if (writeEnabled && (w_op == OP_JEQ)) r_state <= S_BR_WAIT;
        S_BR_WAIT: if (isJeq) r_state <= S_RUN;
        default:   r_state <= S_RUN;
      endcase
    end
  end

  // Later assignments win: load bus over float bus, issue tag over load tag and bus clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= TAG_NONE;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (f_hit(r_tag[i], floatOutSrc, w_flt_act)) begin
          r_val[i] <= floatOut;
          r_tag[i] <= TAG_NONE;
        end
        if (f_hit(r_tag[i], loadOutSrc, w_ld_act)) begin
          r_val[i] <= loadOut;
          r_tag[i] <= TAG_NONE;
        end
        if (ldTagValid && (ldTagReg == i[3:0]))
          r_tag[i] <= ldTag;
        if (writeEnabled && w_writes_rd && (w_rd == i[3:0]))
          r_tag[i] <= nextRA;
      end
    end
  end

endmodule
